// File: rtl/alu_operand_stage.sv
// ID->EX pipeline register feeding the RV32I ALU: captures the decoded instruction,
// forwards results from MEM/WB into held operands and stalls decode for one load-use bubble.
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rd_addr,
  input  logic [7:0]  id_ctrl,
  input  logic        flush,
  input  logic        ex_ready,
  input  logic [4:0]  mem_fwd_addr,
  input  logic [31:0] mem_fwd_data,
  input  logic [4:0]  wb_fwd_addr,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_valid,
  output logic [31:0] in_a,
  output logic [31:0] in_b,
  output logic [31:0] ex_rs2_data,
  output logic [2:0]  funct3,
  output logic        funct7_4,
  output logic        alu_en,
  output logic        alu_imm,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_is_load
);

  localparam int XLEN = 32;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  // Field positions inside id_ctrl
  localparam int C_F7   = 3;
  localparam int C_EN   = 4;
  localparam int C_IMM  = 5;
  localparam int C_PC   = 6;
  localparam int C_LOAD = 7;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [4:0]        r_rs1_addr;
  logic [4:0]        r_rs2_addr;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rd_addr;
  logic [7:0]        r_ctrl;

  logic              w_hazard;
  logic              w_capture;
  logic              w_rs1_fwd_match;
  logic              w_rs2_fwd_match;
  logic [XLEN-1:0]   w_rs1_fwd;
  logic [XLEN-1:0]   w_rs2_fwd;
  logic [XLEN-1:0]   w_id_rs1_wb;
  logic [XLEN-1:0]   w_id_rs2_wb;

  // MEM result beats WB result; x0 is hard-wired zero and never forwarded.
  function automatic logic [XLEN-1:0] fwd_full(
    input logic [4:0]      a,
    input logic [XLEN-1:0] r,
    input logic [4:0]      m_addr,
    input logic [XLEN-1:0] m_data,
    input logic [4:0]      w_addr,
    input logic [XLEN-1:0] w_data
  );
    if (a != 5'd0 && a == m_addr)
      fwd_full = m_data;
    else if (a != 5'd0 && a == w_addr)
      fwd_full = w_data;
    else
      fwd_full = r;
  endfunction

  // The register file is not write-through, so a same-cycle WB write must be bypassed.
  function automatic logic [XLEN-1:0] fwd_wb(
    input logic [4:0]      a,
    input logic [XLEN-1:0] r,
    input logic [4:0]      w_addr,
    input logic [XLEN-1:0] w_data
  );
    if (a != 5'd0 && a == w_addr)
      fwd_wb = w_data;
    else
      fwd_wb = r;
  endfunction

  assign ex_valid   = (r_state == S_FULL);
  assign ex_rd_addr = ex_valid ? r_rd_addr : 5'd0;
  assign ex_is_load = ex_valid & r_ctrl[C_LOAD];

  assign w_hazard = ex_valid & ex_is_load & (ex_rd_addr != 5'd0) & id_valid &
                    ((id_rs1_addr == ex_rd_addr) | (id_rs2_addr == ex_rd_addr));

  assign id_ready  = (~ex_valid | ex_ready) & ~w_hazard & ~flush;
  assign w_capture = id_valid & id_ready;

  assign w_rs1_fwd = fwd_full(r_rs1_addr, r_rs1_data, mem_fwd_addr, mem_fwd_data,
                              wb_fwd_addr, wb_fwd_data);
  assign w_rs2_fwd = fwd_full(r_rs2_addr, r_rs2_data, mem_fwd_addr, mem_fwd_data,
                              wb_fwd_addr, wb_fwd_data);

  // Flags kept for readability of the stall refresh path below
  assign w_rs1_fwd_match = (w_rs1_fwd != r_rs1_data);
  assign w_rs2_fwd_match = (w_rs2_fwd != r_rs2_data);

  assign w_id_rs1_wb = fwd_wb(id_rs1_addr, id_rs1_data, wb_fwd_addr, wb_fwd_data);
  assign w_id_rs2_wb = fwd_wb(id_rs2_addr, id_rs2_data, wb_fwd_addr, wb_fwd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_pc       <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd_addr  <= '0;
      r_ctrl     <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else if (w_capture) begin
      r_state    <= S_FULL;
      r_pc       <= id_pc;
      r_rs1_addr <= id_rs1_addr;
      r_rs2_addr <= id_rs2_addr;
      r_rs1_data <= w_id_rs1_wb;
      r_rs2_data <= w_id_rs2_wb;
      r_imm      <= id_imm;
      r_rd_addr  <= id_rd_addr;
      r_ctrl     <= id_ctrl;
    end else if (r_state == S_FULL && ex_ready) begin
      r_state <= S_EMPTY;
    end else if (r_state == S_FULL) begin
      // Stalled: latch any producer retiring now so it is not lost next cycle.
      if (w_rs1_fwd_match) r_rs1_data <= w_rs1_fwd;
      if (w_rs2_fwd_match) r_rs2_data <= w_rs2_fwd;
    end
  end

  assign in_a        = r_ctrl[C_PC]  ? r_pc  : w_rs1_fwd;
  assign in_b        = r_ctrl[C_IMM] ? r_imm : w_rs2_fwd;
  assign ex_rs2_data = w_rs2_fwd;
  assign funct3      = r_ctrl[2:0];
  assign funct7_4    = r_ctrl[C_F7];
  assign alu_en      = ex_valid & r_ctrl[C_EN];
  assign alu_imm     = r_ctrl[C_IMM];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized checks of alu_operand_stage against a transaction-level model
// of the held instruction and the forwarding rules.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [7:0]  id_ctrl;
  logic        flush, ex_ready;
  logic [4:0]  mem_fwd_addr, wb_fwd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid;
  logic [31:0] in_a, in_b, ex_rs2_data;
  logic [2:0]  funct3;
  logic        funct7_4, alu_en, alu_imm, ex_is_load;
  logic [4:0]  ex_rd_addr;

  int total = 0;
  int bad   = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rd_addr(id_rd_addr), .id_ctrl(id_ctrl), .flush(flush), .ex_ready(ex_ready),
    .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .in_a(in_a), .in_b(in_b), .ex_rs2_data(ex_rs2_data),
    .funct3(funct3), .funct7_4(funct7_4), .alu_en(alu_en), .alu_imm(alu_imm),
    .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  // Model of the instruction occupying the stage
  typedef struct {
    bit          valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [7:0]  ctrl;
  } instr_t;
  instr_t m;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] r);
    if (a != 0 && a == mem_fwd_addr) return mem_fwd_data;
    if (a != 0 && a == wb_fwd_addr)  return wb_fwd_data;
    return r;
  endfunction

  function automatic logic [31:0] wbfwd(input logic [4:0] a, input logic [31:0] r);
    return (a != 0 && a == wb_fwd_addr) ? wb_fwd_data : r;
  endfunction

  function automatic bit exp_ready();
    bit haz;
    haz = m.valid && m.ctrl[7] && m.rd != 0 && id_valid &&
          (id_rs1_addr == m.rd || id_rs2_addr == m.rd);
    return (!m.valid || ex_ready) && !haz && !flush;
  endfunction

  task automatic model_reset();
    m = '{valid: 1'b0, pc: 0, rs1v: 0, rs2v: 0, imm: 0, rs1a: 0, rs2a: 0, rd: 0, ctrl: 0};
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = exp_ready();
    if (flush) m.valid = 0;
    else if (id_valid && rdy) begin
      m.valid = 1; m.pc = id_pc; m.imm = id_imm; m.rd = id_rd_addr; m.ctrl = id_ctrl;
      m.rs1a = id_rs1_addr; m.rs2a = id_rs2_addr;
      m.rs1v = wbfwd(id_rs1_addr, id_rs1_data);
      m.rs2v = wbfwd(id_rs2_addr, id_rs2_data);
    end else if (m.valid && ex_ready) m.valid = 0;
    else if (m.valid) begin
      m.rs1v = fwd(m.rs1a, m.rs1v);
      m.rs2v = fwd(m.rs2a, m.rs2v);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    check("id_ready", 32'(id_ready), 32'(exp_ready()));
    check("in_a", in_a, m.ctrl[6] ? m.pc : fwd(m.rs1a, m.rs1v));
    check("in_b", in_b, m.ctrl[5] ? m.imm : fwd(m.rs2a, m.rs2v));
    check("ex_rs2_data", ex_rs2_data, fwd(m.rs2a, m.rs2v));
    check("funct3", 32'(funct3), 32'(m.ctrl[2:0]));
    check("funct7_4", 32'(funct7_4), 32'(m.ctrl[3]));
    check("alu_en", 32'(alu_en), 32'(m.valid & m.ctrl[4]));
    check("alu_imm", 32'(alu_imm), 32'(m.ctrl[5]));
    check("ex_rd_addr", 32'(ex_rd_addr), m.valid ? 32'(m.rd) : 32'd0);
    check("ex_is_load", 32'(ex_is_load), 32'(m.valid & m.ctrl[7]));
  endtask

  // Inputs settle, outputs are compared, then one clock edge is taken.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] r1, r2,
                        input logic [31:0] d1, d2, imm, input logic [4:0] rd,
                        input logic [7:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1_addr = r1; id_rs2_addr = r2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_rd_addr = rd; id_ctrl = ctrl;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0; ex_ready = 1;
    mem_fwd_addr = 0; mem_fwd_data = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_ex_valid", 32'(ex_valid), 0);
    check("reset_in_a", in_a, 0);
    check("reset_id_ready", 32'(id_ready), 1);
    rst_n = 1;
    @(negedge clk);

    // Async reset while FULL with in_a = pc = 0x10
    set_id(1, 32'h10, 0, 0, 0, 0, 0, 5'd3, 8'h50);
    step();
    idle(); ex_ready = 0;
    #1;
    check("pre_reset_in_a", in_a, 32'h10);
    rst_n = 0;
    #1;
    check("async_rst_ex_valid", 32'(ex_valid), 0);
    check("async_rst_in_a", in_a, 0);
    check("async_rst_alu_en", 32'(alu_en), 0);
    model_reset();
    rst_n = 1; ex_ready = 1;
    @(negedge clk);
    #1;
    check("post_rst_id_ready", 32'(id_ready), 1);
    step();

    // addi x5,x0,7 ; add x6,x5,x5 with MEM forwarding
    set_id(1, 32'h100, 0, 0, 0, 0, 32'd7, 5'd5, 8'h30);
    step();
    set_id(1, 32'h104, 5, 5, 32'hBAD0, 32'hBAD1, 0, 5'd6, 8'h10);
    step();
    idle(); mem_fwd_addr = 5; mem_fwd_data = 7;
    #1;
    check("add_in_a", in_a, 7);
    check("add_in_b", in_b, 7);
    check("add_funct3", 32'(funct3), 0);
    check("add_alu_imm", 32'(alu_imm), 0);
    step();
    idle();
    step();

    // lw x5 then add x6,x5,x1: one bubble, then WB forward
    set_id(1, 32'h200, 5'd2, 0, 32'h40, 0, 32'h4, 5'd5, 8'hB2);
    step();
    set_id(1, 32'h204, 5, 1, 32'hBAD2, 32'h11, 0, 5'd6, 8'h10);
    #1;
    check("loaduse_id_ready", 32'(id_ready), 0);
    step();
    #1;
    check("bubble_ex_valid", 32'(ex_valid), 0);
    step();
    idle(); wb_fwd_addr = 5; wb_fwd_data = 32'h1234;
    #1;
    check("loaduse_in_a", in_a, 32'h1234);
    step();
    idle();

    // sub x8,x7,x1 stalled 3 cycles; WB of x7 during the stall
    set_id(1, 32'h300, 7, 1, 32'h1111, 32'h2, 0, 5'd8, 8'h18);
    step();
    idle(); ex_ready = 0;
    step();
    wb_fwd_addr = 7; wb_fwd_data = 32'hDEAD;
    step();
    wb_fwd_addr = 0; wb_fwd_data = 0;
    step();
    ex_ready = 1;
    #1;
    check("stall_in_a", in_a, 32'hDEAD);
    check("stall_funct7_4", 32'(funct7_4), 1);
    step();

    // Flush with both ID and EX valid
    set_id(1, 32'h400, 1, 2, 3, 4, 5, 5'd9, 8'h10);
    step();
    set_id(1, 32'h404, 1, 2, 3, 4, 5, 5'd10, 8'h10);
    flush = 1;
    #1;
    check("flush_id_ready", 32'(id_ready), 0);
    step();
    idle();
    #1;
    check("flush_ex_valid", 32'(ex_valid), 0);
    step();

    // x0 is never forwarded
    set_id(1, 32'h500, 0, 0, 0, 0, 0, 5'd1, 8'h10);
    wb_fwd_addr = 0; wb_fwd_data = 32'hFFFF;
    step();
    idle(); wb_fwd_addr = 0; wb_fwd_data = 32'hFFFF;
    #1;
    check("x0_in_a", in_a, 0);
    step();

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 8'($urandom));
      flush        = ($urandom_range(0, 15) == 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      mem_fwd_addr = 5'($urandom_range(0, 3));
      mem_fwd_data = $urandom;
      wb_fwd_addr  = 5'($urandom_range(0, 3));
      wb_fwd_data  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
